// File: rtl/sr_latch_driver.sv
// Drives an enabled SR latch from a valid/ready command interface: timed set/reset pulse,
// return to hold, then readback check with a saturating error count.
module sr_latch_driver #(
  parameter int unsigned PULSE_W  = 2,
  parameter int unsigned SETTLE_W = 1,
  parameter int unsigned CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic             req_op,
  output logic             req_ready,
  output logic             e,
  output logic [1:0]       sr,
  input  logic             q_fb,
  input  logic             qb_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned CntMax = (PULSE_W > SETTLE_W) ? PULSE_W : SETTLE_W;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CNT_W-1:0] ErrMax = '1;

  typedef enum logic [1:0] {StIdle, StDrive, StSettle, StCheck} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            op_q;
  logic            mismatch;

  // Case-equality so that 11, 00 and X/Z readback all register as a mismatch.
  assign mismatch = (q_fb !== op_q) || (qb_fb !== ~op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      e         <= 1'b0;
      sr        <= 2'b00;
      req_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      e    <= 1'b1;
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            state_q   <= StDrive;
            cnt_q     <= CntW'(PULSE_W - 1);
            sr        <= req_op ? 2'b10 : 2'b01;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            sr        <= 2'b00;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end
        end
        StDrive: begin
          if (cnt_q == '0) begin
            sr <= 2'b00;
            if (SETTLE_W == 0) begin
              state_q <= StCheck;
              cnt_q   <= '0;
            end else begin
              state_q <= StSettle;
              cnt_q   <= CntW'(SETTLE_W - 1);
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StCheck;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StCheck: begin
          // Readback is sampled on the closing edge; flags appear with ready so a
          // new command can be accepted in the done cycle.
          state_q   <= StIdle;
          cnt_q     <= '0;
          sr        <= 2'b00;
          busy      <= 1'b0;
          req_ready <= 1'b1;
          done      <= 1'b1;
          err       <= mismatch;
          if (mismatch && (err_cnt != ErrMax)) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          sr      <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: offset-from-accept reference model checked every cycle,
// plus directed sequences with literal expectations.
module tb_sr_latch_driver;

  localparam int unsigned P     = 2;
  localparam int unsigned S     = 1;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned LAT   = P + S + 2;
  localparam int unsigned SAT   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid, req_op, req_ready;
  logic             e, busy, done, err;
  logic [1:0]       sr;
  logic             q_fb, qb_fb;
  logic [CNT_W-1:0] err_cnt;

  sr_latch_driver #(.PULSE_W(P), .SETTLE_W(S), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_ready(req_ready), .e(e), .sr(sr), .q_fb(q_fb), .qb_fb(qb_fb),
    .busy(busy), .done(done), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  // Latch environment: 0 = behavioural latch, 1 = stuck set, 2 = forbidden 11.
  int   fb_mode = 0;
  logic lq = 1'b0;
  always @(posedge clk) begin
    if (e && sr == 2'b10) lq <= 1'b1;
    else if (e && sr == 2'b01) lq <= 1'b0;
  end
  assign q_fb  = (fb_mode == 0) ? lq  : 1'b1;
  assign qb_fb = (fb_mode == 0) ? ~lq : (fb_mode == 2);

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: k counts cycles since the accept edge (k=1 first drive cycle).
  bit      m_up = 0, m_active = 0, m_op = 0, m_err = 0, m_rdy;
  int      m_k = 0, m_cnt = 0, n_accept = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_up = 0; m_active = 0; m_k = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_rdy = m_up && (!m_active || m_k >= LAT);
      m_up  = 1;
      if (m_active && m_k < LAT) begin
        m_k++;
        if (m_k == LAT) begin
          m_err = (q_fb !== m_op) || (qb_fb !== ~m_op);
          if (m_err && m_cnt < SAT) m_cnt++;
        end
      end else if (m_active) begin
        m_k = LAT + 1;
      end
      if (m_rdy && req_valid) begin
        m_active = 1; m_k = 1; m_op = req_op; n_accept++;
      end
    end
  end

  logic [1:0] exp_sr;
  bit         exp_done, exp_busy, exp_rdy;
  always @(negedge clk) begin
    exp_sr   = (m_active && m_k <= P) ? (m_op ? 2'b10 : 2'b01) : 2'b00;
    exp_busy = m_active && m_k < LAT;
    exp_done = m_active && m_k == LAT;
    exp_rdy  = m_up && (!m_active || m_k >= LAT);
    chk("e", e, m_up);
    chk("sr", sr, exp_sr);
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, exp_busy);
    chk("done", done, exp_done);
    chk("err", err, exp_done && m_err);
    chk("err_cnt", err_cnt, m_cnt);
  end

  // Raise valid and return at negedge+2 of the first drive cycle (k=1).
  task automatic issue(input logic op);
    int start;
    start = n_accept;
    @(negedge clk); #2;
    req_valid = 1'b1; req_op = op;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (n_accept != start) break;
    end
    #2 req_valid = 1'b0;
    chk("accept", n_accept - start, 1);
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  int base;

  initial begin
    req_valid = 1'b0; req_op = 1'b0; rst_n = 1'b1;
    #1 rst_n = 1'b0;
    // 1. reset / idle
    step();
    chk("rst e", e, 0); chk("rst sr", sr, 0); chk("rst ready", req_ready, 0);
    chk("rst cnt", err_cnt, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    step();
    chk("idle e", e, 1); chk("idle sr", sr, 0); chk("idle ready", req_ready, 1);

    // 2. set command, good readback
    issue(1'b1);
    chk("set k1 sr", sr, 2'b10);
    step(); chk("set k2 sr", sr, 2'b10);
    step(); chk("set k3 sr", sr, 2'b00); chk("set k3 busy", busy, 1);
    step(); chk("set k4 sr", sr, 2'b00);
    step(); chk("set done", done, 1); chk("set err", err, 0); chk("set ready", req_ready, 1);

    // 3. reset command, stuck-set readback
    fb_mode = 1;
    issue(1'b0);
    chk("rst k1 sr", sr, 2'b01); chk("rst k1 cnt", err_cnt, 0);
    step(); chk("rst k2 sr", sr, 2'b01);
    step(); step(); step();
    chk("rst done", done, 1); chk("rst err", err, 1); chk("rst cnt1", err_cnt, 1);
    fb_mode = 0;
    repeat (2) step();

    // 4. valid held, op wiggling mid-command; second accept in the done cycle
    base = n_accept;
    @(negedge clk); #2 req_valid = 1'b1; req_op = 1'b1;
    for (int i = 0; i < 20 && n_accept == base; i++) @(negedge clk);
    #2 req_op = 1'b0;
    @(negedge clk); #2 req_op = 1'b1; chk("b2b k2 sr", sr, 2'b10);
    @(negedge clk); #2 req_op = 1'b0;
    @(negedge clk); #2 req_op = 1'b1; chk("b2b k4 busy", busy, 1);
    @(negedge clk); #2 req_op = 1'b0;
    chk("b2b done", done, 1); chk("b2b ready", req_ready, 1); chk("b2b err", err, 0);
    chk("b2b one accept", n_accept - base, 1);
    step();
    chk("b2b second", n_accept - base, 2); chk("b2b sr01", sr, 2'b01);
    #1 req_valid = 1'b0;
    repeat (LAT + 1) step();

    // 5. forbidden readback, then saturate the counter
    fb_mode = 2;
    issue(1'b1);
    repeat (LAT - 1) step();
    chk("fbd done", done, 1); chk("fbd err", err, 1);
    base = n_accept;
    @(negedge clk); #2 req_valid = 1'b1; req_op = 1'b1;
    for (int i = 0; i < 260 * LAT + 50 && n_accept < base + 260; i++) @(negedge clk);
    #2 req_valid = 1'b0;
    chk("sat accepts", n_accept - base, 260);
    repeat (LAT + 2) step();
    chk("sat cnt", err_cnt, SAT);
    fb_mode = 0;

    // 6. reset during second drive cycle aborts
    issue(1'b1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("abort e", e, 0); chk("abort sr", sr, 0); chk("abort cnt", err_cnt, 0);
    chk("abort busy", busy, 0);
    @(negedge clk); #2 rst_n = 1'b1;
    repeat (2) step();
    issue(1'b0);
    chk("post k1 sr", sr, 2'b01);
    repeat (LAT - 1) step();
    chk("post done", done, 1); chk("post err", err, 0); chk("post cnt", err_cnt, 0);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
